// File: rtl/z80_bus_decoder.sv
// Runtime-configurable memory/IO region decoder with per-region wait states,
// interrupt-vector return and first-unmapped-access capture for the tv80 bus.
module z80_bus_decoder #(
  parameter int NREG = 4,
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int WSW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic [AW-1:0]      A,
  input  logic [NREG*DW-1:0] rd_data,
  input  logic [DW-1:0]      ivec,
  input  logic [NREG*AW-1:0] region_base,
  input  logic [NREG*AW-1:0] region_mask,
  input  logic [NREG-1:0]    region_io,
  input  logic [NREG*WSW-1:0] region_ws,
  input  logic [NREG-1:0]    region_en,
  input  logic               err_clr,
  output logic [NREG-1:0]    rd_cs,
  output logic [NREG-1:0]    wr_cs,
  output logic [DW-1:0]      di,
  output logic               wait_n,
  output logic               err,
  output logic [AW-1:0]      err_addr
);

  logic mem_acc, io_acc, intack, acc, start;
  logic acc_q, acc_d;
  logic [WSW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [NREG-1:0] hit;
  logic [NREG-1:0] win;
  logic            any_hit;
  logic [DW-1:0]   sel_data;
  logic [WSW-1:0]  sel_ws;
  logic            unmapped;

  assign mem_acc = !mreq_n && (!rd_n || !wr_n);
  assign io_acc  = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign intack  = !iorq_n && !m1_n;
  assign acc     = mem_acc || io_acc || intack;
  assign start   = acc && !acc_q;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      hit[i] = region_en[i]
             && (region_io[i] ? io_acc : mem_acc)
             && (((A ^ region_base[i*AW +: AW])
                  & region_mask[i*AW +: AW]) == '0);
    end
  end

  // Scan downward so the lowest hitting index is the last one written.
  always_comb begin
    win      = '0;
    any_hit  = 1'b0;
    sel_data = '0;
    sel_ws   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win      = '0;
        win[i]   = 1'b1;
        any_hit  = 1'b1;
        sel_data = rd_data[i*DW +: DW];
        sel_ws   = region_ws[i*WSW +: WSW];
      end
    end
  end

  assign rd_cs = win & {NREG{!rd_n}};
  assign wr_cs = win & {NREG{!wr_n}};

  always_comb begin
    di = '1;
    if (any_hit && !rd_n) begin
      di = sel_data;
    end else if (intack) begin
      di = ivec;
    end
  end

  assign unmapped = start && (mem_acc || io_acc) && !any_hit;

  always_comb begin
    acc_d = acc;
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = (any_hit && !intack) ? sel_ws : '0;
    end else if (!acc) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A fresh capture outranks a simultaneous clear.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (unmapped && (!err_q || err_clr)) begin
      err_d      = 1'b1;
      err_addr_d = A;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wait_n   = (cnt_q == '0);
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
